// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and types for the 4-to-1 round-robin stream mux
package stream_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - combinational rotate-priority search over four requests starting at ptr
module rr_arbiter_4
    import stream_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_t               ptr,
    output logic              gnt_valid,
    output ch_t               gnt_idx
);

    // Walk from the farthest offset down to ptr so the nearest requester is the last to overwrite.
    always_comb begin
        ch_t idx;
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + ch_t'(i);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_4to1_rr.sv
// rtl/stream_mux_4to1_rr.sv - four valid/ready streams merged round-robin with packet lock into one registered stream
module stream_mux_4to1_rr #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [1:0]               out_ch,
    input  logic                     out_ready
);

    import stream_mux_pkg::*;

    if (NUM_CH != stream_mux_pkg::NUM_CH) begin : g_bad_num_ch
        $error("stream_mux_4to1_rr supports exactly 4 channels");
    end

    mux_state_t        state;
    mux_state_t        state_nxt;
    ch_t               ptr;
    ch_t               lock_ch;
    ch_t               gnt_idx;
    logic              gnt_valid;
    logic              can_load;
    logic              accept;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [NUM_CH-1:0] req;

    assign can_load = !out_valid || out_ready;

    // While a packet is open only its owner may compete, so the arbiter sees a single request.
    always_comb begin
        req = in_valid;
        if (state == LOCK) begin
            req = in_valid & (NUM_CH'(1) << lock_ch);
        end
    end

    rr_arbiter_4 u_arb (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_data = in_data[gnt_idx*DATA_W +: DATA_W];
    assign sel_last = in_last[gnt_idx];
    assign accept   = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !sel_last) state_nxt = LOCK;
            LOCK:    if (accept && sel_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst_n gates the grant so no channel sees an accept while the block is held in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && can_load && gnt_valid) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            lock_ch <= '0;
        end else begin
            if (accept && sel_last) begin
                ptr <= gnt_idx + 1'b1;
            end
            if (accept && state == IDLE && !sel_last) begin
                lock_ch <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
